// File: rtl/hub75_pkg.sv
// hub75_pkg: shared FSM encodings, counter-width helpers and pixel word layout for the HUB75 BCM driver.
package hub75_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] LATCH   = 2'd2;
    localparam logic [1:0] DISPLAY = 2'd3;

    // Colour slot positions inside a pixel word {R,G,B}, in units of COLOR_DEPTH bits.
    localparam int R_SLOT = 2;
    localparam int G_SLOT = 1;
    localparam int B_SLOT = 0;

    // Width of a counter indexing 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    // Width of the display period counter: must hold the longest plane period.
    function automatic int period_w(input int base_period, input int color_depth);
        return $clog2((base_period << (color_depth - 1)) + 1);
    endfunction

endpackage

// File: rtl/hub75_bcm_driver_if.sv
// hub75_bcm_driver_if: AXI-Stream column input of the HUB75 driver.
//   tdata  : one column, lane l pixel p at (l*NUM_PIXELS+p)*3*COLOR_DEPTH, pixel word {R,G,B}
//   tvalid : column valid
//   tready : driver shadow buffer empty
//   tlast  : last column of a frame
interface hub75_bcm_driver_if #(
    parameter int NUM_PIXELS  = 64,
    parameter int NUM_LANES   = 2,
    parameter int COLOR_DEPTH = 3
);

    logic [NUM_LANES*NUM_PIXELS*3*COLOR_DEPTH-1:0] tdata;
    logic                                          tvalid;
    logic                                          tready;
    logic                                          tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: display period timer; done is high in the last of BASE_PERIOD<<plane cycles after start.
//   clk_in, rst_in : clock, async active-high reset
//   start          : load the period for plane (one cycle before the display window)
//   plane          : bit plane index
//   done           : final cycle of the display window
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int BASE_PERIOD = 10,
    parameter int COLOR_DEPTH = 3
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start,
    input  logic [cnt_w(COLOR_DEPTH)-1:0] plane,
    output logic                          done
);

    localparam int CW = period_w(BASE_PERIOD, COLOR_DEPTH);

    logic [CW-1:0] cnt;

    // Counts down to zero; loading period-1 makes the window exactly period cycles long.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            cnt <= '0;
        else if (start)
            cnt <= CW'((BASE_PERIOD << plane) - 1);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = cnt == '0;

endmodule

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: shifts one column per stream beat out as COLOR_DEPTH BCM planes with latch/OE sequencing.
//   clk_in, rst_in    : clock, async active-high reset
//   s                 : column stream (slave), one-deep shadow buffer behind tready
//   rgb_out           : lane l -> [3l]=R, [3l+1]=G, [3l+2]=B of the current plane bit
//   led_clk           : panel shift clock (registered)
//   led_latch         : panel latch
//   led_output_enable : panel OE, active low
//   col_done          : last display cycle of a column's final plane
//   frame_done        : col_done of a column that arrived with tlast
module hub75_bcm_driver
    import hub75_pkg::*;
#(
    parameter int NUM_PIXELS  = 64,
    parameter int NUM_LANES   = 2,
    parameter int COLOR_DEPTH = 3,
    parameter int BASE_PERIOD = 10
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    hub75_bcm_driver_if.slave      s,
    output logic [3*NUM_LANES-1:0] rgb_out,
    output logic                   led_clk,
    output logic                   led_latch,
    output logic                   led_output_enable,
    output logic                   col_done,
    output logic                   frame_done
);

    localparam int WW = 3 * COLOR_DEPTH;
    localparam int DW = NUM_LANES * NUM_PIXELS * WW;
    localparam int PW = cnt_w(COLOR_DEPTH);
    localparam int XW = cnt_w(NUM_PIXELS);

    logic [1:0]    state;
    logic [PW-1:0] plane;
    logic [XW-1:0] pix;
    logic [DW-1:0] shadow_data, active_data;
    logic          shadow_valid, shadow_last, active_last;
    logic          accept, last_plane, load, tm_done;
    logic [WW-1:0] bits;

    assign accept            = s.tvalid && s.tready;
    assign last_plane        = plane == PW'(COLOR_DEPTH - 1);
    assign col_done          = state == DISPLAY && tm_done && last_plane;
    assign frame_done        = col_done && active_last;
    // Shadow moves to active from IDLE, or straight out of the final display cycle.
    assign load              = shadow_valid && (state == IDLE || col_done);
    assign led_latch         = state == LATCH;
    assign led_output_enable = state != DISPLAY;

    hub75_bcm_timer #(
        .BASE_PERIOD(BASE_PERIOD),
        .COLOR_DEPTH(COLOR_DEPTH)
    ) u_timer (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .start (state == LATCH),
        .plane (plane),
        .done  (tm_done)
    );

    // Current plane bit of each lane's current pixel; zero outside SHIFT.
    always_comb begin
        rgb_out = '0;
        bits    = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            bits = WW'(active_data >> (WW * (l * NUM_PIXELS + int'(pix)) + int'(plane)));
            rgb_out[3*l]   = state == SHIFT && bits[R_SLOT*COLOR_DEPTH];
            rgb_out[3*l+1] = state == SHIFT && bits[G_SLOT*COLOR_DEPTH];
            rgb_out[3*l+2] = state == SHIFT && bits[B_SLOT*COLOR_DEPTH];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            plane        <= '0;
            pix          <= '0;
            led_clk      <= 1'b0;
            shadow_valid <= 1'b0;
            shadow_last  <= 1'b0;
            active_last  <= 1'b0;
            s.tready     <= 1'b0;
        end else begin
            // Lags shadow_valid by a cycle on release, but drops at once on acceptance.
            s.tready <= !(shadow_valid || accept);
            if (accept) begin
                shadow_valid <= 1'b1;
                shadow_last  <= s.tlast;
            end else if (load) begin
                shadow_valid <= 1'b0;
            end
            if (load) begin
                active_last <= shadow_last;
                state       <= SHIFT;
                plane       <= '0;
                pix         <= '0;
                led_clk     <= 1'b0;
            end else if (state == SHIFT) begin
                led_clk <= !led_clk;
                if (led_clk) begin
                    pix   <= pix == XW'(NUM_PIXELS - 1) ? '0 : pix + 1'b1;
                    state <= pix == XW'(NUM_PIXELS - 1) ? LATCH : SHIFT;
                end
            end else if (state == LATCH) begin
                state <= DISPLAY;
            end else if (state == DISPLAY && tm_done) begin
                state <= last_plane ? IDLE : SHIFT;
                plane <= last_plane ? plane : plane + 1'b1;
            end
        end
    end

    // Payload registers carry no reset; validity is tracked by the flags above.
    always_ff @(posedge clk_in) begin
        if (accept)
            shadow_data <= s.tdata;
        if (load)
            active_data <= shadow_data;
    end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb_hub75_bcm_driver: directed checks of the HUB75 BCM driver at default and minimal parameters.
module tb_hub75_bcm_driver;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    hub75_bcm_driver_if #(.NUM_PIXELS(64), .NUM_LANES(2), .COLOR_DEPTH(3)) s0 ();
    hub75_bcm_driver_if #(.NUM_PIXELS(2), .NUM_LANES(1), .COLOR_DEPTH(1)) s1 ();

    logic [5:0] rgb0;
    logic       lclk0, lat0, oe0, cd0, fd0;
    logic [2:0] rgb1;
    logic       lclk1, lat1, oe1, cd1, fd1;

    hub75_bcm_driver #(
        .NUM_PIXELS(64), .NUM_LANES(2), .COLOR_DEPTH(3), .BASE_PERIOD(10)
    ) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .s(s0), .rgb_out(rgb0), .led_clk(lclk0),
        .led_latch(lat0), .led_output_enable(oe0), .col_done(cd0), .frame_done(fd0)
    );

    hub75_bcm_driver #(
        .NUM_PIXELS(2), .NUM_LANES(1), .COLOR_DEPTH(1), .BASE_PERIOD(1)
    ) u_small (
        .clk_in(clk_in), .rst_in(rst_in), .s(s1), .rgb_out(rgb1), .led_clk(lclk1),
        .led_latch(lat1), .led_output_enable(oe1), .col_done(cd1), .frame_done(fd1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int run, nr, rises, lat_n, done_at, fd_n, fd_at, cd_n, a_done, b_done, bp_hi;
        int runs [3];
        logic pclk;
        s0.tvalid = 1'b0; s0.tlast = 1'b0; s0.tdata = '0;
        s1.tvalid = 1'b0; s1.tlast = 1'b0; s1.tdata = '0;
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("rst_tready", s0.tready, 0);
        chk("rst_oe", oe0, 1);
        chk("rst_lclk", lclk0, 0);
        chk("rst_rgb", rgb0, 0);
        chk("rst_col_done", {cd0, fd0}, 0);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("release_tready", s0.tready, 1);

        // Single column: lane 0 pixel 0 = R7 G0 B5
        s0.tdata[8:0] = 9'b111_000_101;
        s0.tvalid = 1'b1;
        @(negedge clk_in);
        s0.tvalid = 1'b0;
        chk("accept_tready_low", s0.tready, 0);
        rises = 0; nr = 0; run = 0; lat_n = 0; done_at = -1; fd_n = 0; pclk = 1'b0;
        for (int k = 1; k <= 470; k++) begin
            @(negedge clk_in);
            if (lclk0 && !pclk) rises++;
            pclk = lclk0;
            if (lat0) lat_n++;
            if (!oe0) run++;
            else if (run > 0) begin
                if (nr < 3) runs[nr] = run;
                nr++;
                run = 0;
            end
            if (cd0 && done_at < 0) done_at = k;
            if (fd0) fd_n++;
            if (k == 1) chk("p0_pix0_rgb", rgb0, 6'b000101);
            if (k == 2) chk("p0_pix0_hold", {lclk0, rgb0}, 7'b1_000101);
            if (k == 3) chk("p0_pix1_rgb", rgb0, 0);
            if (k == 129) chk("latch_cycle", {lat0, oe0, lclk0}, 3'b110);
            if (k == 130) chk("display_start", {lat0, oe0}, 2'b00);
            if (k == 140) chk("p1_pix0_rgb", rgb0, 6'b000001);
            if (k == 289) chk("p2_pix0_rgb", rgb0, 6'b000101);
        end
        chk("led_clk_rises", rises, 192);
        chk("latch_cycles", lat_n, 3);
        chk("display_windows", nr, 3);
        chk("oe_low_plane0", runs[0], 10);
        chk("oe_low_plane1", runs[1], 20);
        chk("oe_low_plane2", runs[2], 40);
        chk("col_done_cycle", done_at, 457);
        chk("no_frame_done", fd_n, 0);

        // Back-to-back A (lane 1 pixel 63 = R0 G6 B3) then B (lane 0 pixel 0 = R1 G2 B4, tlast)
        s0.tdata = '0;
        s0.tdata[1143 +: 9] = 9'b000_110_011;
        s0.tlast = 1'b0;
        s0.tvalid = 1'b1;
        @(negedge clk_in);
        s0.tdata = '0;
        s0.tdata[8:0] = 9'b001_010_100;
        s0.tlast = 1'b1;
        chk("b2b_tready_low", s0.tready, 0);
        cd_n = 0; fd_n = 0; fd_at = -1; a_done = -1; b_done = -1; bp_hi = 0;
        for (int k = 1; k <= 925; k++) begin
            @(negedge clk_in);
            if (k == 1) chk("b2b_tready_shift", s0.tready, 0);
            if (k == 2) chk("b2b_tready_rise", s0.tready, 1);
            if (k == 3) begin
                chk("b2b_second_taken", s0.tready, 0);
                s0.tdata = '1;
                s0.tlast = 1'b0;
            end
            if (k >= 3 && k <= 458 && s0.tready) bp_hi++;
            if (k == 127) chk("lane1_p0_pix63", rgb0, 6'b100000);
            if (k == 128) chk("lane1_p0_pix63_hold", {lclk0, rgb0}, 7'b1_100000);
            if (k == 266) chk("lane1_p1_pix63", rgb0, 6'b110000);
            if (cd0) begin
                cd_n++;
                if (cd_n == 1) a_done = k; else b_done = k;
            end
            if (fd0) begin
                fd_n++;
                fd_at = k;
            end
            if (k == 458) begin
                chk("b2b_no_gap", {oe0, lclk0, rgb0}, {1'b1, 1'b0, 6'b000001});
                s0.tvalid = 1'b0;
            end
        end
        chk("bp_tready_held_low", bp_hi, 0);
        chk("a_col_done", a_done, 457);
        chk("b_col_done", b_done, 914);
        chk("col_done_pulses", cd_n, 2);
        chk("frame_done_pulses", fd_n, 1);
        chk("frame_done_cycle", fd_at, 914);
        chk("b2b_idle_end", {s0.tready, oe0}, 2'b11);

        // Asynchronous reset in the middle of SHIFT
        s0.tdata = '0;
        s0.tdata[8:0] = 9'b111_000_101;
        s0.tlast = 1'b0;
        s0.tvalid = 1'b1;
        @(negedge clk_in);
        s0.tvalid = 1'b0;
        @(negedge clk_in);
        chk("pre_rst_rgb", rgb0, 6'b000101);
        @(posedge clk_in);
        #2;
        chk("pre_rst_lclk", lclk0, 1);
        rst_in = 1'b1;
        #1;
        chk("async_rst_outputs", {rgb0, lclk0, oe0, lat0, s0.tready, cd0}, {6'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("post_rst_tready_low", s0.tready, 0);
        @(negedge clk_in);
        chk("post_rst_tready_high", s0.tready, 1);
        repeat (5) @(negedge clk_in);
        chk("post_rst_idle", {oe0, lclk0, rgb0}, {1'b1, 1'b0, 6'b0});

        // Minimal configuration: 2 pixels, 1 lane, 1 plane, period 1
        s1.tdata = 6'b010_101;
        s1.tlast = 1'b1;
        s1.tvalid = 1'b1;
        @(negedge clk_in);
        s1.tvalid = 1'b0;
        chk("small_tready_low", s1.tready, 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            if (k == 1) chk("small_pix0", {rgb1, lclk1, oe1}, {3'b101, 1'b0, 1'b1});
            if (k == 2) chk("small_pix0_hold", {rgb1, lclk1}, {3'b101, 1'b1});
            if (k == 3) chk("small_pix1", rgb1, 3'b010);
            if (k == 4) chk("small_pix1_hold", {lat1, oe1, lclk1}, 3'b011);
            if (k == 5) chk("small_latch", {lat1, oe1, lclk1}, 3'b110);
            if (k == 6) chk("small_display_done", {oe1, cd1, fd1}, 3'b011);
            if (k == 7) chk("small_idle", {oe1, cd1, fd1}, 3'b100);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hub75_bcm_driver.md
Name: hub75_bcm_driver

Overview:
Parametrised HUB75 column driver for the rotating display. It accepts one column of multi-bit colour pixels per AXI-Stream beat for every output lane, and shifts the column out as COLOR_DEPTH binary-coded-modulation bit planes with latch and output-enable sequencing. A one-deep shadow buffer accepts the next column while the current one is displayed. It sits between the column/angle fetch logic and the panel pins.

Parameters:
NUM_PIXELS, 64, pixels shifted per lane per bit plane (≥2)
NUM_LANES, 2, independent rgb lanes (upper/lower panel halves), ≥1
COLOR_DEPTH, 3, bits per colour channel = number of bit planes (1..8)
BASE_PERIOD, 10, display cycles of LSB plane; plane b displays BASE_PERIOD<<b cycles (≥1)

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
s_tdata  in  NUM_LANES*NUM_PIXELS*3*COLOR_DEPTH  column; lane l pixel p at offset (l*NUM_PIXELS+p)*3*COLOR_DEPTH, pixel word {R,G,B}, R in MSBs
s_tvalid  in  1  column valid
s_tready  out  1  shadow buffer empty, registered
s_tlast  in  1  last column of a frame (one rotation)
rgb_out  out  3*NUM_LANES  lane l: [3l]=R, [3l+1]=G, [3l+2]=B of current plane bit
led_clk  out  1  panel shift clock, registered (no clock gating)
led_latch  out  1  panel latch
led_output_enable  out  1  panel OE, active low (1 = blanked)
col_done  out  1  one-cycle pulse when last plane of a column finishes display
frame_done  out  1  one-cycle pulse coincident with col_done when that column arrived with s_tlast=1

Behaviour:
- Reset (async, immediate): rgb_out=0, led_clk=0, led_latch=0, led_output_enable=1, s_tready=0, col_done=0, frame_done=0, shadow and active buffers invalid, state IDLE. First cycle after release: s_tready=1.
- Handshake: beat accepted on rising clk when s_tvalid&&s_tready; data+tlast captured into shadow, shadow_valid=1, s_tready=0 next cycle. s_tready=!shadow_valid, registered; it rises the cycle after shadow moves to active. s_tdata/s_tlast ignored when not accepted.
- States: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE: OE=1, led_clk=0. If shadow_valid: copy shadow to active, clear shadow_valid, plane=0, pixel=0 -> SHIFT.
- SHIFT: 2 cycles per pixel, pixel 0 first. Even cycle: rgb_out=bit[plane] of each lane's pixel, led_clk=0. Odd cycle: led_clk=1, data held. After pixel NUM_PIXELS-1 odd cycle -> LATCH. OE=1 throughout. Duration 2*NUM_PIXELS cycles.
- LATCH: one cycle, led_latch=1, led_clk=0, OE=1 -> DISPLAY.
- DISPLAY: OE=0 for exactly BASE_PERIOD<<plane cycles, led_latch=0. At end: if plane<COLOR_DEPTH-1: plane+1 -> SHIFT. Else pulse col_done (and frame_done if active tlast) and -> IDLE, or directly load shadow -> SHIFT the same cycle if shadow_valid (no IDLE cycle).
- Column time (defaults): 3*(128+1)+(10+20+40)=457 cycles.
- Period counter width $clog2((BASE_PERIOD<<(COLOR_DEPTH-1))+1); no overflow permitted.
- Upstream beat during the final DISPLAY cycle with shadow empty is accepted; shadow load and shadow-to-active transfer never coincide because s_tready is 0 whenever shadow_valid=1.
- Reset mid-operation: outputs go to reset values immediately, partially shifted data discarded, both buffers invalid.

Decomposition:
- hub75_pkg: state enum (IDLE, SHIFT, LATCH, DISPLAY), width helper functions (plane counter, pixel counter, period counter widths), pixel word field offset constants.
- Sub-module hub75_bcm_timer: takes plane index and start pulse, asserts done after BASE_PERIOD<<plane cycles. Owns the period counter.

Test Plan:
- Reset: assert rst_in asynchronously mid-SHIFT -> same cycle OE=1, led_clk=0, rgb_out=0, s_tready=0; s_tready=1 one cycle after release.
- Single column, defaults, pixel 0 lane 0 = R7 G0 B5, all else 0 -> plane 0 rgb_out[2:0]=3'b101 at pixel 0, 64 led_clk rising edges per plane, latch pulse 1 cycle, OE low 10/20/40 cycles, col_done at cycle 457 after accept.
- Back-to-back: two beats presented continuously -> second accepted the cycle after first enters SHIFT; second column's SHIFT starts the cycle after first's col_done, no IDLE gap.
- tlast: column with s_tlast=1 -> frame_done pulses once together with col_done; column with s_tlast=0 -> no frame_done.
- Backpressure: s_tvalid held with shadow full -> s_tready=0, data not recaptured, and changed s_tdata does not affect the displayed column.
- Params NUM_LANES=1, COLOR_DEPTH=1, BASE_PERIOD=1, NUM_PIXELS=2 -> 4 SHIFT cycles, 1 LATCH cycle, 1 DISPLAY cycle, col_done 6 cycles after SHIFT entry.
